// File: rtl/seq_pkg.sv
// Shared types and constants for the seq_v2 datapath.
//   INSTR_W / ADDR_W : instruction and address widths
//   PC_INC           : byte stride between sequential instructions
//   RESET_PC_DEFAULT : default PC after reset
//   fetch_entry_t    : {pc, instr} pair carried from fetch to decode
//   align_pc()       : clears the byte-offset bits of an address
package seq_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & ~(ADDR_W'(3));
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: CodeMem address/data, execute-stage redirect, and the
// valid/ready instruction stream toward decode.
//   master : the fetch stage (drives pc_o and the out_* stream)
//   slave  : the environment (CodeMem, execute, decode)
interface instr_fetch_if;
  logic [seq_pkg::ADDR_W-1:0]  pc_o;
  logic [seq_pkg::INSTR_W-1:0] instr_i;
  logic                        redirect_valid;
  logic [seq_pkg::ADDR_W-1:0]  redirect_pc;
  logic                        out_valid;
  logic                        out_ready;
  logic [seq_pkg::INSTR_W-1:0] out_instr;
  logic [seq_pkg::ADDR_W-1:0]  out_pc;

  modport master (
    output pc_o, out_valid, out_instr, out_pc,
    input  instr_i, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  pc_o, out_valid, out_instr, out_pc,
    output instr_i, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
//   clk, rst_n : clock, async active-low reset (pointers/count only)
//   push, pop  : write din at tail / advance head
//   flush      : empty the queue; overrides push and pop
//   din, dout  : entry in / raw head entry out (undefined when empty)
//   count      : occupancy, 0..DEPTH
//   empty,full : occupancy flags
module fetch_queue import seq_pkg::*; #(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem[head_q];

  // A push into a full queue is legal only when the head leaves that cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; readers gate it with empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[tail_q] <= din;
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses CodeMem combinationally and queues
// {pc, instr} pairs for decode. Redirects from execute flush the queue and
// reload the PC (word aligned).
//   clk, rst_n : clock, async active-low reset
//   bus        : instr_fetch_if.master (pc_o/instr_i, redirect, out stream)
module instr_fetch import seq_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_fetch_if.master   bus
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              deq, enq;
  fetch_entry_t      q_din, q_dout;
  logic [CNT_W-1:0]  q_count;
  logic              q_empty, q_full;

  assign bus.pc_o = pc_q;

  assign deq = bus.out_valid && bus.out_ready;
  // A full queue may still accept when its head is leaving this cycle.
  assign enq = !bus.redirect_valid && (!q_full || deq);

  assign q_din = '{pc: pc_q, instr: bus.instr_i};

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) pc_d = align_pc(bus.redirect_pc);
    else if (enq)           pc_d = pc_q + PC_INC;  // wraps modulo 2^32
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (enq),
    .pop   (deq),
    .flush (bus.redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // Head storage is unreset, so force zeros whenever nothing is queued.
  assign bus.out_valid = (q_count != '0);
  assign bus.out_instr = q_empty ? '0 : q_dout.instr;
  assign bus.out_pc    = q_empty ? '0 : q_dout.pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random
// ready/redirect traffic, compared each cycle against a queue-based model.
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  ent_t        mq[$];
  logic [31:0] mpc;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // CodeMem: fixed words at 0/4/8, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h1111_1111;
      32'h4: return 32'h2222_2222;
      32'h8: return 32'h3333_3333;
      default: return {a[15:0] ^ 16'hA5C3, a[17:2]};
    endcase
  endfunction

  always_comb bus.instr_i = mem_word(bus.pc_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model.
  task automatic check_all(input string tag);
    chk({tag, ".pc_o"},      bus.pc_o,                  mpc);
    chk({tag, ".out_valid"}, 32'(bus.out_valid),        32'(mq.size() != 0));
    chk({tag, ".out_pc"},    bus.out_pc,    mq.size() != 0 ? mq[0].pc    : 32'h0);
    chk({tag, ".out_instr"}, bus.out_instr, mq.size() != 0 ? mq[0].instr : 32'h0);
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = RST_PC;
  endtask

  // Called at a negedge: check, drive inputs, advance model, move to next negedge.
  task automatic step(input string tag, input logic redir, input logic [31:0] rpc,
                      input logic ready);
    bit deq;
    int n;
    check_all(tag);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.out_ready      = ready;
    n   = mq.size();
    deq = (n != 0) && ready;
    if (redir) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (deq) void'(mq.pop_front());
      if (n < DEPTH || deq) begin
        mq.push_back('{pc: mpc, instr: mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.pc_o",      bus.pc_o,             RST_PC);
    chk("rst.out_valid", 32'(bus.out_valid),   32'h0);
    chk("rst.out_pc",    bus.out_pc,           32'h0);
    chk("rst.out_instr", bus.out_instr,        32'h0);
    rst_n = 1'b1;

    // Stream 0/4/8 with decode always ready
    for (int i = 0; i < 4; i++) step("stream", 1'b0, '0, 1'b1);
    // Back-pressure: queue fills, PC freezes
    for (int i = 0; i < 5; i++) step("stall", 1'b0, '0, 1'b0);
    // Full queue with ready: pop+push each cycle
    for (int i = 0; i < 4; i++) step("fullrun", 1'b0, '0, 1'b1);
    // Fill again, then redirect to an unaligned target
    for (int i = 0; i < 3; i++) step("fill", 1'b0, '0, 1'b0);
    step("redir103", 1'b1, 32'h0000_0103, 1'b0);
    chk("redir103.pc_o",  bus.pc_o,           32'h0000_0100);
    chk("redir103.valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 3; i++) step("after103", 1'b0, '0, 1'b1);
    // PC wrap at top of address space
    step("redirtop", 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("wrap.pc0", bus.pc_o, 32'hFFFF_FFFC);
    step("wrap1", 1'b0, '0, 1'b1);
    chk("wrap.pc1", bus.pc_o, 32'h0000_0000);
    step("wrap2", 1'b0, '0, 1'b1);
    chk("wrap.pc2", bus.pc_o, 32'h0000_0004);
    step("wrap3", 1'b0, '0, 1'b1);

    // Random ready / redirect traffic (redirect with ready=1 covers
    // dequeue-during-flush)
    for (int i = 0; i < 150; i++) begin
      logic        r;
      logic [31:0] t;
      r = ($urandom_range(0, 9) == 0);
      t = $urandom;
      step("rand", r, t, logic'($urandom_range(0, 9) < 7));
    end

    // Asynchronous reset between edges
    step("pre_arst", 1'b0, '0, 1'b0);
    step("pre_arst", 1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst.pc_o",      bus.pc_o,           RST_PC);
    chk("arst.out_pc",    bus.out_pc,         32'h0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("post_arst", 1'b0, '0, 1'b1);
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage of the seq_v2 datapath: owns the program counter, drives `CodeMem.pc`, and captures the combinational `CodeMem.instr` response into a small instruction queue. The queue presents {pc, instr} pairs to the decode stage over a valid/ready handshake. It also accepts redirects (branch/jump targets) from the execute stage, and a redirect flushes the queue.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `QUEUE_DEPTH`, default 2: instruction queue entries; power of two, at least 2.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `pc_o`, output, 32: fetch address to `CodeMem.pc`; equals the internal PC register.
- `instr_i`, input, 32: instruction from `CodeMem.instr`; combinational from `pc_o` within the same cycle.
- `redirect_valid`, input, 1: load a new PC this cycle.
- `redirect_pc`, input, 32: redirect target; bits [1:0] are ignored and forced to 0.
- `out_valid`, output, 1: queue head is valid.
- `out_ready`, input, 1: decode accepts the head this cycle.
- `out_instr`, output, 32: instruction at the queue head.
- `out_pc`, output, 32: address of `out_instr`.

## Operation
- State: the PC register, plus a queue of QUEUE_DEPTH entries of {pc[31:0], instr[31:0]} with head/tail pointers and a count of log2(QUEUE_DEPTH)+1 bits.
- Dequeue: fires when `out_valid && out_ready`; the head pointer advances.
- Enqueue condition: `!redirect_valid && (count < QUEUE_DEPTH || dequeue)`. This lets a full queue with a simultaneous dequeue still accept a new entry.
- On enqueue, {pc_o, instr_i} is written at the tail and PC <= PC + 4.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no error flag.
- Stall: when the enqueue condition is false and there is no redirect, PC holds. `pc_o` stays stable, so the same address is re-read next cycle.
- Redirect has the highest priority:
  - The queue is flushed (count = 0, pointers reset) and PC <= {redirect_pc[31:2], 2'b00}.
  - No enqueue happens that cycle.
  - A dequeue in the same cycle still counts as consumed by decode, but its entry is discarded by the flush.
- Reset, asynchronous on `rst_n` low:
  - PC = RESET_PC, count = 0, pointers = 0.
  - `out_valid` = 0.
  - `out_instr` and `out_pc` = 0. Queue storage is not reset, so the head outputs are muxed to 0 when empty.
  - Asserting reset mid-operation discards all queued entries immediately.
- `out_valid` = (count != 0). `out_instr` and `out_pc` are read from the head entry.

## Timing
- CodeMem is combinational. `instr_i` is sampled at the same edge that advances PC.
- Fetch-to-decode latency is 1 cycle: an instruction at address A on `pc_o` in cycle n appears on `out_instr` with `out_pc` = A in cycle n+1, provided the queue was empty.
- After `rst_n` deasserts:
  - Cycle 0: `pc_o` = RESET_PC.
  - First edge: enqueue.
  - Cycle 1: `out_valid` = 1 and `pc_o` = RESET_PC + 4.
- Redirect latency: `redirect_valid` in cycle n gives `pc_o` = target in cycle n+1, `out_valid` = 0 in cycle n+1, and the target instruction on `out_instr` in cycle n+2.
- Sustained throughput is 1 instruction/cycle while `out_ready` = 1.
- Decode must hold `out_ready` independent of `out_valid`; no combinational path from `out_ready` to `pc_o` is required beyond the enqueue condition.

## Structure
- Shared package `seq_pkg`:
  - `INSTR_W` = 32, `ADDR_W` = 32, `PC_INC` = 4.
  - `RESET_PC_DEFAULT`.
  - A fetch-entry packed struct {pc, instr}.
- One sub-module, `fetch_queue`: a synchronous FIFO with flush.
  - Inputs: push, pop, flush, din.
  - Outputs: dout, count, empty, full.
  - Asynchronous active-low reset.
- `instr_fetch` contains the PC register, the enqueue/redirect logic, and instantiates `fetch_queue`. It is instantiated next to `CodeMem` in the top level.

## Test plan
- Reset release with memory words 0x11111111 / 0x22222222 / 0x33333333 at addresses 0 / 4 / 8, `out_ready` = 1 -> `out_instr` is 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, with `out_pc` = 0, 4, 8.
- Hold `out_ready` = 0 for 5 cycles -> count saturates at 2, `pc_o` freezes at 8, and `out_pc` stays at 0. Release `out_ready` -> no entry is lost or duplicated.
- Queue full with `out_ready` = 1 -> a pop and a push happen in the same cycle, count stays 2, and PC advances by 4.
- Redirect to 0x0000_0103 while the queue holds 2 entries -> next cycle `out_valid` = 0 and `pc_o` = 0x0000_0100; the cycle after, `out_pc` = 0x100.
- Redirect to 0xFFFF_FFFC, then free-run -> `pc_o` sequence is 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Assert `rst_n` low asynchronously mid-stream (between edges) -> `out_valid` drops to 0 and `pc_o` returns to RESET_PC before the next clock edge.
